// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Job timer sequencing stage resets, source reads and output
//            pixel flags for the RGB->YCbCr->DCT->Q->IQ->IDCT->RGB pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
    parameter int DCT_START   = 3,
    parameter int QUANT_START = 83,
    parameter int RDCT_START  = 86,
    parameter int OUT_START   = 150,
    parameter int NUM_BLOCKS  = 4096,
    parameter int BLK_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             mem_en_read,
    output logic             dct_rst,
    output logic             quant_rst,
    output logic             rdct_rst,
    output logic             out_valid,
    output logic [5:0]       pix_cnt,
    output logic [BLK_W-1:0] block_cnt
);

    localparam logic [31:0] TOTAL   = 32'(NUM_BLOCKS) * 32'd64;
    localparam logic [31:0] DCT_T   = 32'(DCT_START);
    localparam logic [31:0] QUANT_T = 32'(QUANT_START);
    localparam logic [31:0] RDCT_T  = 32'(RDCT_START);
    localparam logic [31:0] OUT_T   = 32'(OUT_START);
    localparam logic [31:0] JOB_END = OUT_T + TOTAL;

    if (!(DCT_START < QUANT_START && QUANT_START <= RDCT_START &&
          RDCT_START < OUT_START && NUM_BLOCKS >= 1 &&
          BLK_W >= $clog2(NUM_BLOCKS))) begin : g_param_check
        $error("pipeline_sequencer: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [31:0]        t_q;
    logic               busy_q, done_q, mem_q, dct_q, quant_q, rdct_q, valid_q;
    logic [5:0]         pix_q;
    logic [BLK_W-1:0]   block_q;

    logic [31:0]        k_d;
    logic [BLK_W+5:0]   idx_d;
    logic               run_d, done_d, valid_d;

    // k_d is the job cycle the next clock edge enters; all outputs are
    // decoded from it so they are registered yet aligned with t.
    always_comb begin
        k_d     = (state_q == S_IDLE) ? 32'd0 : t_q + 32'd1;
        idx_d   = (BLK_W+6)'(k_d - OUT_T);
        valid_d = (k_d >= OUT_T) && (k_d < JOB_END);
        run_d   = (state_q == S_IDLE) ? start : (!abort && (k_d != JOB_END));
        done_d  = (state_q == S_RUN) && !abort && (k_d == JOB_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mem_q   <= 1'b0;
            dct_q   <= 1'b1;
            quant_q <= 1'b1;
            rdct_q  <= 1'b1;
            valid_q <= 1'b0;
            pix_q   <= 6'd0;
            block_q <= '0;
        end else if (run_d) begin
            state_q <= S_RUN;
            t_q     <= k_d;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            mem_q   <= (k_d < TOTAL);
            dct_q   <= (k_d < DCT_T);
            quant_q <= (k_d < QUANT_T);
            rdct_q  <= (k_d < RDCT_T);
            valid_q <= valid_d;
            pix_q   <= valid_d ? idx_d[5:0] : 6'd0;
            block_q <= valid_d ? idx_d[BLK_W+5:6] : '0;
        end else begin
            state_q <= S_IDLE;
            t_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= done_d;
            mem_q   <= 1'b0;
            dct_q   <= 1'b1;
            quant_q <= 1'b1;
            rdct_q  <= 1'b1;
            valid_q <= 1'b0;
            pix_q   <= 6'd0;
            block_q <= '0;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_en_read = mem_q;
    assign dct_rst     = dct_q;
    assign quant_rst   = quant_q;
    assign rdct_rst    = rdct_q;
    assign out_valid   = valid_q;
    assign pix_cnt     = pix_q;
    assign block_cnt   = block_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Randomized self-checking bench against a job-level timing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

    localparam int NB    = 2;
    localparam int BW    = 4;
    localparam int DS    = 3;
    localparam int QS    = 83;
    localparam int RS    = 86;
    localparam int OS    = 150;
    localparam int TOTAL = NB * 64;
    localparam int JEND  = OS + TOTAL;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, mem_en_read, dct_rst, quant_rst, rdct_rst, out_valid;
    logic [5:0]    pix_cnt;
    logic [BW-1:0] block_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: whether a job is running, its cycle index, done flag.
    bit m_run  = 1'b0;
    int m_k    = 0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .DCT_START  (DS),
        .QUANT_START(QS),
        .RDCT_START (RS),
        .OUT_START  (OS),
        .NUM_BLOCKS (NB),
        .BLK_W      (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_en_read(mem_en_read),
        .dct_rst    (dct_rst),
        .quant_rst  (quant_rst),
        .rdct_rst   (rdct_rst),
        .out_valid  (out_valid),
        .pix_cnt    (pix_cnt),
        .block_cnt  (block_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (job t=%0d, running=%0d, time %0t)",
                     tag, got, exp, m_k, m_run, $time);
        end
    endtask

    task automatic check_all();
        bit v;
        v = m_run && (m_k >= OS) && (m_k < JEND);
        check("busy",        32'(busy),        32'(m_run));
        check("done",        32'(done),        32'(m_done));
        check("mem_en_read", 32'(mem_en_read), 32'(m_run && (m_k < TOTAL)));
        check("dct_rst",     32'(dct_rst),     32'(!(m_run && (m_k >= DS))));
        check("quant_rst",   32'(quant_rst),   32'(!(m_run && (m_k >= QS))));
        check("rdct_rst",    32'(rdct_rst),    32'(!(m_run && (m_k >= RS))));
        check("out_valid",   32'(out_valid),   32'(v));
        check("pix_cnt",     32'(pix_cnt),     v ? 32'((m_k - OS) % 64) : 32'd0);
        check("block_cnt",   32'(block_cnt),   v ? 32'((m_k - OS) / 64) : 32'd0);
    endtask

    task automatic model_step(input bit s, input bit a);
        if (!rst) begin
            m_run = 1'b0; m_k = 0; m_done = 1'b0;
        end else if (!m_run) begin
            m_done = 1'b0;
            if (s) begin
                m_run = 1'b1; m_k = 0;
            end
        end else if (a) begin
            m_run = 1'b0; m_k = 0; m_done = 1'b0;
        end else if (m_k + 1 == JEND) begin
            m_run = 1'b0; m_k = 0; m_done = 1'b1;
        end else begin
            m_k++;
        end
    endtask

    // Entered and left at a falling edge; outputs are checked there.
    task automatic cycle(input bit s, input bit a);
        start = s;
        abort = a;
        @(posedge clk);
        model_step(s, a);
        @(negedge clk);
        check_all();
    endtask

    // Advance with random start noise (must be ignored while busy).
    task automatic run_to(input int target);
        for (int i = 0; i < 2 * JEND && !(m_run && m_k == target); i++)
            cycle(bit'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, bit'($urandom_range(0, 1)));

        // Nominal job through done and back to idle
        cycle(1'b1, 1'b0);
        for (int i = 0; i < JEND + 5; i++) cycle(1'b0, 1'b0);

        // Back-to-back with start held high
        for (int i = 0; i < 3 * (JEND + 1); i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Abort at t=100
        cycle(1'b1, 1'b0);
        run_to(100);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Start with abort also high, then abort on the last valid cycle
        cycle(1'b1, 1'b1);
        run_to(JEND - 1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Random start/abort traffic
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Asynchronous reset between edges at t=160
        cycle(1'b1, 1'b0);
        run_to(160);
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_busy",      32'(busy),        32'd0);
        check("async_out_valid", 32'(out_valid),   32'd0);
        check("async_dct_rst",   32'(dct_rst),     32'd1);
        check("async_rdct_rst",  32'(rdct_rst),    32'd1);
        check("async_mem_en",    32'(mem_en_read), 32'd0);
        check("async_pix_cnt",   32'(pix_cnt),     32'd0);
        m_run = 1'b0; m_k = 0; m_done = 1'b0;
        @(negedge clk);
        cycle(1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
